// File: rtl/memory_hierarchy_pkg.sv
// Shared definitions for the memory hierarchy: arbiter state encoding,
// requester identifiers and the default address/line widths of offchip_memory.
package memory_hierarchy_pkg;

  localparam int MEM_ADDR_WIDTH = 6;
  localparam int MEM_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_REQ0 = 1'b0,
    OWNER_REQ1 = 1'b1
  } owner_t;

endpackage

// File: rtl/memory_read_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: combinational choice from the requests and the
// priority pointer; the pointer moves past the served requester on grant_done.
module rr_arbiter2
  import memory_hierarchy_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   req0,
  input  logic   req1,
  input  logic   grant_done,
  input  owner_t done_owner,
  output logic   grant_valid,
  output owner_t grant_sel
);

  owner_t pointer;

  always_comb begin
    grant_valid = req0 | req1;
    grant_sel   = OWNER_REQ0;
    if (req0 && req1) begin
      grant_sel = pointer;
    end else if (req1) begin
      grant_sel = OWNER_REQ1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pointer <= OWNER_REQ0;
    end else if (grant_done) begin
      pointer <= (done_owner == OWNER_REQ0) ? OWNER_REQ1 : OWNER_REQ0;
    end
  end

endmodule

// File: rtl/memory_read_arbiter.sv
// Shares the offchip_memory read port between two block-fetch requesters,
// holding each grant until data returns or the read is aborted on timeout.
module memory_read_arbiter
  import memory_hierarchy_pkg::*;
#(
  parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MEM_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_read_enable,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  output logic                  req0_read_ready,
  output logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_read_enable,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  output logic                  req1_read_ready,
  output logic [DATA_WIDTH-1:0] req1_data,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_data_ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  timeout_error
);

  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_t             state_q, state_d;
  owner_t                 owner_q, grant_sel;
  logic                   grant_valid, grant_done, load_grant, capture;
  logic                   read_enable_d, ready0_d, ready1_d, timeout_d;
  logic [COUNT_WIDTH-1:0] count_q;

  rr_arbiter2 u_rr_arbiter2 (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0_read_enable),
    .req1        (req1_read_enable),
    .grant_done  (grant_done),
    .done_owner  (owner_q),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Data arriving on the final BUSY cycle wins over the timeout abort.
  always_comb begin
    state_d       = state_q;
    load_grant    = 1'b0;
    capture       = 1'b0;
    grant_done    = 1'b0;
    read_enable_d = 1'b0;
    ready0_d      = 1'b0;
    ready1_d      = 1'b0;
    timeout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d       = BUSY;
          load_grant    = 1'b1;
          read_enable_d = 1'b1;
        end
      end
      BUSY: begin
        read_enable_d = 1'b1;
        if (mem_data_ready) begin
          state_d       = DONE;
          read_enable_d = 1'b0;
          capture       = 1'b1;
          grant_done    = 1'b1;
          ready0_d      = (owner_q == OWNER_REQ0);
          ready1_d      = (owner_q == OWNER_REQ1);
        end else if (count_q == COUNT_LAST) begin
          state_d       = DONE;
          read_enable_d = 1'b0;
          grant_done    = 1'b1;
          timeout_d     = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q         <= OWNER_REQ0;
      count_q         <= '0;
      mem_read_enable <= 1'b0;
      mem_address     <= '0;
      req0_read_ready <= 1'b0;
      req1_read_ready <= 1'b0;
      req0_data       <= '0;
      req1_data       <= '0;
      timeout_error   <= 1'b0;
    end else begin
      mem_read_enable <= read_enable_d;
      req0_read_ready <= ready0_d;
      req1_read_ready <= ready1_d;
      timeout_error   <= timeout_d;
      if (load_grant) begin
        owner_q     <= grant_sel;
        mem_address <= (grant_sel == OWNER_REQ0) ? req0_address : req1_address;
        count_q     <= '0;
      end else if (state_q == BUSY && count_q != COUNT_MAX) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
      if (capture && owner_q == OWNER_REQ0) begin
        req0_data <= mem_data;
      end
      if (capture && owner_q == OWNER_REQ1) begin
        req1_data <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed bench for memory_read_arbiter: reset, single and alternating reads,
// request glitches, timeout abort and reset in the middle of a read.
module tb_memory_read_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_read_enable;
  logic [5:0]  req0_address;
  logic        req0_read_ready;
  logic [63:0] req0_data;
  logic        req1_read_enable;
  logic [5:0]  req1_address;
  logic        req1_read_ready;
  logic [63:0] req1_data;
  logic        mem_read_enable;
  logic [5:0]  mem_address;
  logic        mem_data_ready;
  logic [63:0] mem_data;
  logic        timeout_error;

  int compared;
  int mismatched;

  typedef struct {
    logic        r0_en;
    logic [5:0]  r0_addr;
    logic        r1_en;
    logic [5:0]  r1_addr;
    logic        mem_rdy;
    logic [63:0] mem_dat;
    logic        e_re;
    logic [5:0]  e_addr;
    logic        e_rr0;
    logic        e_rr1;
    logic [63:0] e_d0;
    logic [63:0] e_d1;
    logic        e_to;
  } vec_t;

  vec_t vecs[21];

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] CF = 64'hCAFE_F00D_55AA_33CC;
  localparam logic [63:0] A0 = 64'hA0A0_0000_0000_0001;
  localparam logic [63:0] B1 = 64'hB1B1_0000_0000_0002;
  localparam logic [63:0] A2 = 64'hA2A2_0000_0000_0003;
  localparam logic [63:0] B3 = 64'hB3B3_0000_0000_0004;
  localparam logic [63:0] TD = 64'h5A5A_6B6B_7C7C_8D8D;

  memory_read_arbiter #(
    .ADDR_WIDTH     (6),
    .DATA_WIDTH     (64),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req0_read_enable (req0_read_enable),
    .req0_address     (req0_address),
    .req0_read_ready  (req0_read_ready),
    .req0_data        (req0_data),
    .req1_read_enable (req1_read_enable),
    .req1_address     (req1_address),
    .req1_read_ready  (req1_read_ready),
    .req1_data        (req1_data),
    .mem_read_enable  (mem_read_enable),
    .mem_address      (mem_address),
    .mem_data_ready   (mem_data_ready),
    .mem_data         (mem_data),
    .timeout_error    (timeout_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_read_enable = v.r0_en;
    req0_address     = v.r0_addr;
    req1_read_enable = v.r1_en;
    req1_address     = v.r1_addr;
    mem_data_ready   = v.mem_rdy;
    mem_data         = v.mem_dat;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " mem_re"}, 64'(mem_read_enable), 64'd0);
    checkOutput({tag, " mem_addr"}, 64'(mem_address), 64'd0);
    checkOutput({tag, " rr0"}, 64'(req0_read_ready), 64'd0);
    checkOutput({tag, " rr1"}, 64'(req1_read_ready), 64'd0);
    checkOutput({tag, " d0"}, req0_data, 64'd0);
    checkOutput({tag, " d1"}, req1_data, 64'd0);
    checkOutput({tag, " timeout"}, 64'(timeout_error), 64'd0);
  endtask

  initial begin
    int re_cycles;
    int to_seen;
    int rr_seen;
    compared   = 0;
    mismatched = 0;

    vecs[0]  = '{1'b1, 6'h15, 1'b0, 6'h00, 1'b0, 64'd0,  1'b1, 6'h15, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0};
    vecs[1]  = '{1'b1, 6'h15, 1'b0, 6'h00, 1'b0, 64'd0,  1'b1, 6'h15, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0};
    vecs[2]  = '{1'b1, 6'h15, 1'b0, 6'h00, 1'b1, DB,     1'b0, 6'h15, 1'b1, 1'b0, DB,    64'd0, 1'b0};
    vecs[3]  = '{1'b0, 6'h15, 1'b0, 6'h00, 1'b0, 64'd0,  1'b0, 6'h15, 1'b0, 1'b0, DB,    64'd0, 1'b0};
    vecs[4]  = '{1'b0, 6'h00, 1'b1, 6'h2A, 1'b0, 64'd0,  1'b1, 6'h2A, 1'b0, 1'b0, DB,    64'd0, 1'b0};
    vecs[5]  = '{1'b0, 6'h00, 1'b0, 6'h3F, 1'b0, 64'd0,  1'b1, 6'h2A, 1'b0, 1'b0, DB,    64'd0, 1'b0};
    vecs[6]  = '{1'b0, 6'h00, 1'b0, 6'h3F, 1'b1, CF,     1'b0, 6'h2A, 1'b0, 1'b1, DB,    CF,    1'b0};
    vecs[7]  = '{1'b0, 6'h00, 1'b0, 6'h3F, 1'b0, 64'd0,  1'b0, 6'h2A, 1'b0, 1'b0, DB,    CF,    1'b0};
    vecs[8]  = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b1, '1,     1'b0, 6'h2A, 1'b0, 1'b0, DB,    CF,    1'b0};
    vecs[9]  = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b0, 64'd0,  1'b1, 6'h01, 1'b0, 1'b0, DB,    CF,    1'b0};
    vecs[10] = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b1, A0,     1'b0, 6'h01, 1'b1, 1'b0, A0,    CF,    1'b0};
    vecs[11] = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b0, 64'd0,  1'b0, 6'h01, 1'b0, 1'b0, A0,    CF,    1'b0};
    vecs[12] = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b0, 64'd0,  1'b1, 6'h02, 1'b0, 1'b0, A0,    CF,    1'b0};
    vecs[13] = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b1, B1,     1'b0, 6'h02, 1'b0, 1'b1, A0,    B1,    1'b0};
    vecs[14] = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b0, 64'd0,  1'b0, 6'h02, 1'b0, 1'b0, A0,    B1,    1'b0};
    vecs[15] = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b0, 64'd0,  1'b1, 6'h01, 1'b0, 1'b0, A0,    B1,    1'b0};
    vecs[16] = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b1, A2,     1'b0, 6'h01, 1'b1, 1'b0, A2,    B1,    1'b0};
    vecs[17] = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b0, 64'd0,  1'b0, 6'h01, 1'b0, 1'b0, A2,    B1,    1'b0};
    vecs[18] = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b0, 64'd0,  1'b1, 6'h02, 1'b0, 1'b0, A2,    B1,    1'b0};
    vecs[19] = '{1'b1, 6'h01, 1'b1, 6'h02, 1'b1, B3,     1'b0, 6'h02, 1'b0, 1'b1, A2,    B3,    1'b0};
    vecs[20] = '{1'b0, 6'h01, 1'b0, 6'h02, 1'b0, 64'd0,  1'b0, 6'h02, 1'b0, 1'b0, A2,    B3,    1'b0};

    // Reset held with both requests and a stray memory strobe active.
    reset            = 1'b1;
    req0_read_enable = 1'b1;
    req0_address     = 6'h0A;
    req1_read_enable = 1'b1;
    req1_address     = 6'h0B;
    mem_data_ready   = 1'b1;
    mem_data         = 64'h1234;
    #1 reset = 1'b0;
    repeat (3) tick();
    checkAllZero("reset");

    mem_data_ready = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("post-reset grant mem_re", 64'(mem_read_enable), 64'd1);
    checkOutput("post-reset grant req0 first", 64'(mem_address), 64'(6'h0A));
    tick();
    tick();
    checkOutput("busy 3 cycles mem_re", 64'(mem_read_enable), 64'd1);

    // Reset mid-read: outputs drop without a clock edge; the late answer is ignored.
    reset = 1'b0;
    #1;
    checkOutput("mid-busy reset mem_re", 64'(mem_read_enable), 64'd0);
    checkOutput("mid-busy reset mem_addr", 64'(mem_address), 64'd0);
    req0_read_enable = 1'b0;
    req1_read_enable = 1'b0;
    tick();
    reset = 1'b1;
    mem_data_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkAllZero($sformatf("late ready %0d", i));
    end
    mem_data_ready = 1'b0;
    mem_data       = 64'd0;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d mem_re", i), 64'(mem_read_enable), 64'(vecs[i].e_re));
      checkOutput($sformatf("v%0d mem_addr", i), 64'(mem_address), 64'(vecs[i].e_addr));
      checkOutput($sformatf("v%0d rr0", i), 64'(req0_read_ready), 64'(vecs[i].e_rr0));
      checkOutput($sformatf("v%0d rr1", i), 64'(req1_read_ready), 64'(vecs[i].e_rr1));
      checkOutput($sformatf("v%0d d0", i), req0_data, vecs[i].e_d0);
      checkOutput($sformatf("v%0d d1", i), req1_data, vecs[i].e_d1);
      checkOutput($sformatf("v%0d timeout", i), 64'(timeout_error), 64'(vecs[i].e_to));
      checkOutput($sformatf("v%0d one ready", i), 64'(req0_read_ready & req1_read_ready), 64'd0);
    end

    // Timeout: both request, memory never answers; req0 owns, then req1 is granted.
    req0_read_enable = 1'b1;
    req0_address     = 6'h33;
    req1_read_enable = 1'b1;
    req1_address     = 6'h34;
    mem_data_ready   = 1'b0;
    re_cycles = 0;
    to_seen   = 0;
    rr_seen   = 0;
    for (int i = 0; i < 40 && to_seen == 0; i++) begin
      tick();
      if (mem_read_enable) re_cycles++;
      if (timeout_error) to_seen = 1;
      if (req0_read_ready || req1_read_ready) rr_seen = 1;
    end
    checkOutput("timeout pulse seen", 64'(to_seen), 64'd1);
    checkOutput("timeout mem_re cycles", 64'(re_cycles), 64'd8);
    checkOutput("timeout no ready", 64'(rr_seen), 64'd0);
    checkOutput("timeout mem_re low", 64'(mem_read_enable), 64'd0);
    checkOutput("timeout mem_addr", 64'(mem_address), 64'(6'h33));
    tick();
    checkOutput("timeout pulse width", 64'(timeout_error), 64'd0);
    checkOutput("timeout d0 held", req0_data, A2);
    tick();
    checkOutput("after timeout grant mem_re", 64'(mem_read_enable), 64'd1);
    checkOutput("after timeout grant req1", 64'(mem_address), 64'(6'h34));
    mem_data_ready = 1'b1;
    mem_data       = TD;
    tick();
    checkOutput("after timeout rr1", 64'(req1_read_ready), 64'd1);
    checkOutput("after timeout rr0", 64'(req0_read_ready), 64'd0);
    checkOutput("after timeout d1", req1_data, TD);
    req0_read_enable = 1'b0;
    req1_read_enable = 1'b0;
    mem_data_ready   = 1'b0;
    tick();
    checkOutput("final rr1 pulse width", 64'(req1_read_ready), 64'd0);
    checkOutput("final mem_re", 64'(mem_read_enable), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
